// File: rtl/encoder_8to3_serial.sv
// Serial priority encoder: accepts a multi-hot request vector and emits the
// index of each set bit, lowest first, one code per out_ready handshake.
module encoder_8to3_serial #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         zero_flag
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state, state_d;
  logic [N-1:0] pending, pending_d;
  logic         zero_flag_d;
  logic [W-1:0] lowest;
  logic         found;
  logic         single;

  // State, pending vector and zero pulse; reset discards any in-flight codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      zero_flag <= zero_flag_d;
    end
  end

  // Lowest set bit of pending (bit 0 has priority) and one-hot detect
  always_comb begin
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending[i] && !found) begin
        lowest = W'(i);
        found  = 1'b1;
      end
    end
    single = (pending != '0) && ((pending & (pending - N'(1))) == '0);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state;
    pending_d   = pending;
    zero_flag_d = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out         = '0;
    out_last    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = enable;
        if (in_valid && enable) begin
          if (in != '0) begin
            pending_d = in;
            state_d   = SCAN;
          end else begin
            zero_flag_d = 1'b1;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out       = lowest;
        out_last  = single;
        if (out_ready) begin
          pending_d[lowest] = 1'b0;
          if (single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_8to3_serial.sv
// Self-checking bench for encoder_8to3_serial: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_encoder_8to3_serial;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       zero_flag;

  int checks = 0;
  int errors = 0;

  // Reference model: codes still owed for the accepted vector, plus zero pulse
  int unsigned m_q[$];
  logic        m_zero = 1'b0;

  encoder_8to3_serial #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        busy;
    int unsigned exp_out;
    busy    = (m_q.size() != 0);
    exp_out = busy ? m_q[0] : 0;
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!busy && enable));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(busy));
    chk({tag, ".out"},       32'(out),       exp_out);
    chk({tag, ".out_last"},  32'(out_last),  32'(m_q.size() == 1));
    chk({tag, ".zero_flag"}, 32'(zero_flag), 32'(m_zero));
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge
  task automatic cycle(input string tag, input logic en, input logic vld,
                       input logic [7:0] vec, input logic ordy);
    @(negedge clk);
    enable    = en;
    in_valid  = vld;
    in        = vec;
    out_ready = ordy;
    #1;
    check_outputs(tag);
    @(posedge clk);
    m_zero = 1'b0;
    if (m_q.size() != 0) begin
      if (ordy) void'(m_q.pop_front());
    end else if (en && vld) begin
      if (vec == 8'h00) m_zero = 1'b1;
      else for (int i = 0; i < 8; i++) if (vec[i]) m_q.push_back(i);
    end
  endtask

  // Asynchronous reset pulse issued between clock edges
  task automatic do_reset(input string tag);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    enable   = 1'b0;
    #1;
    m_q.delete();
    m_zero = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    in        = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Disabled: requests ignored
    for (int i = 0; i < 5; i++) cycle("disabled", 1'b0, 1'b1, 8'h01, 1'b1);

    // Single bit
    cycle("single", 1'b1, 1'b1, 8'b0000_0100, 1'b1);
    for (int i = 0; i < 3; i++) cycle("single", 1'b1, 1'b0, 8'h00, 1'b1);

    // Three bits back to back, enable dropped mid-scan
    cycle("three", 1'b1, 1'b1, 8'b1000_0101, 1'b1);
    cycle("three", 1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cycle("three", 1'b1, 1'b0, 8'h00, 1'b1);

    // All bits with backpressure 1,0,0 pattern
    cycle("full", 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 26; i++) cycle("full", 1'b1, 1'b0, 8'h00, (i % 3) == 0);
    for (int i = 0; i < 2; i++) cycle("full", 1'b1, 1'b0, 8'h00, 1'b1);

    // All-zero vector
    cycle("zero", 1'b1, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle("zero", 1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-scan after codes 0 and 1
    cycle("rstscan", 1'b1, 1'b1, 8'hFF, 1'b1);
    cycle("rstscan", 1'b1, 1'b0, 8'h00, 1'b1);
    cycle("rstscan", 1'b1, 1'b0, 8'h00, 1'b1);
    do_reset("rstscan.async");
    cycle("rstscan", 1'b1, 1'b1, 8'h08, 1'b1);
    for (int i = 0; i < 3; i++) cycle("rstscan", 1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle("rand", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), v,
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset("rand.async");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_8to3_serial.md
ENCODER_8TO3_SERIAL -- requirements
Module: encoder_8to3_serial

Interface
REQ-001 SHALL have parameter N, default 8: request vector width; power of two, 2..256.
REQ-002 SHALL have derived localparam W = log2(N), default 3: code width.
REQ-003 SHALL have clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have enable, input, 1: gates acceptance of new vectors only.
REQ-006 SHALL have in, input, N: multi-hot request vector, bit i = event i.
REQ-007 SHALL have in_valid, input, 1: in holds a vector to accept.
REQ-008 SHALL have in_ready, output, 1: block can accept a vector this cycle.
REQ-009 SHALL have out, output, W: binary index of the current event.
REQ-010 SHALL have out_valid, output, 1: out holds a valid code.
REQ-011 SHALL have out_ready, input, 1: consumer takes the code this cycle.
REQ-012 SHALL have out_last, output, 1: current code is the final one from the accepted vector.
REQ-013 SHALL have zero_flag, output, 1: single-cycle pulse when an all-zero vector is accepted.

Function
REQ-014 SHALL implement FSM with states IDLE and SCAN plus an N-bit pending register.
REQ-015 SHALL drive in_ready = (state==IDLE) && enable, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL accept a vector on an edge where in_valid && in_ready; no other condition loads pending.
REQ-017 SHALL, on accepting a nonzero vector, load pending <= in and go to SCAN; out_valid rises the cycle after acceptance (latency 1).
REQ-018 SHALL, on accepting an all-zero vector, stay in IDLE, leave pending = 0, and assert zero_flag for exactly the next cycle.
REQ-019 SHALL, in SCAN, hold out_valid = 1 and drive out = index of the lowest-numbered set bit of pending (bit 0 highest priority).
REQ-020 SHALL drive out_last = 1 in SCAN iff pending has exactly one bit set.
REQ-021 SHALL, on out_valid && out_ready, clear the bit at index out in pending; if out_last, go to IDLE; otherwise stay in SCAN.
REQ-022 SHALL hold out, out_valid and out_last stable while out_valid && !out_ready (no code dropped or changed under backpressure).
REQ-023 SHALL drive out = 0 and out_last = 0 whenever out_valid = 0.
REQ-024 SHALL NOT let enable affect SCAN: deasserting enable mid-SCAN still completes all pending codes.
REQ-025 SHALL emit exactly popcount(in) codes per accepted nonzero vector, in strictly ascending index order.
REQ-026 SHALL have back-to-back throughput of one code per cycle with out_ready held 1; in_ready returns high the cycle after the last handshake.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state = IDLE, pending = 0, out_valid = 0, out = 0, out_last = 0, zero_flag = 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-SCAN, discard all remaining pending codes; no code from that vector appears after reset release.
REQ-029 SHALL, after rst_n rises, allow acceptance no earlier than the first rising clk edge with rst_n = 1.

Verification
REQ-030 SHALL cover: enable=0, in_valid=1, in=8'h01 for 5 cycles -> in_ready=0, out_valid=0 throughout, zero_flag=0.
REQ-031 SHALL cover: enable=1, in=8'b0000_0100 accepted, out_ready=1 -> one cycle out_valid=1, out=3'd2, out_last=1; in_ready=1 the next cycle.
REQ-032 SHALL cover: in=8'b1000_0101, out_ready=1 -> out=0,2,7 on 3 consecutive cycles, out_last=1 only with 7, in_ready=0 during those 3 cycles.
REQ-033 SHALL cover: in=8'hFF, out_ready toggling 1,0,0,1,... -> codes 0..7 in order, each stable while stalled, 8 handshakes total.
REQ-034 SHALL cover: in=8'h00 accepted -> zero_flag=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 SHALL cover: in=8'hFF, rst_n pulled low asynchronously after codes 0 and 1 -> out_valid=0 before the next clk edge; after release, in=8'h08 yields only out=3'd3 with out_last=1.
